ram_param_clr: RTL and testbench
================================

Name: ram_param_clr

Overview:
- Parametrised successor to the fixed 16K x 16 Hack RAM: depth is 2^ADDRESS_WIDTH words of DATA_WIDTH bits.
- Adds three things the fixed RAM does not have:
  - a registered synchronous read with a valid flag;
  - a selectable read-during-write mode;
  - a hardware clear sequencer that writes INIT_VALUE into every word after reset or on request.
- Sits on the CPU data-memory bus in place of RAM16K.
- Software must wait for busy to fall before issuing accesses.

Parameters:
- ADDRESS_WIDTH, 14, address bits; depth = 2^ADDRESS_WIDTH.
- DATA_WIDTH, 16, word width in bits.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by a clear sweep.
- RDW_MODE, 0, read-during-write to the same address: 0 = write-first (out gets new data), 1 = read-first (out gets old data).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- address, input, ADDRESS_WIDTH, word address for load/read.
- in, input, DATA_WIDTH, write data.
- load, input, 1, write enable; samples in into mem[address] at the rising edge.
- rd_en, input, 1, read request; samples mem[address] into out at the rising edge.
- clear, input, 1, single-cycle request to start a clear sweep.
- out, output, DATA_WIDTH, registered read data.
- out_valid, output, 1, high for exactly one cycle when out was updated by the preceding edge's read.
- busy, output, 1, high while a clear sweep is in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset asserted (immediately, no clock needed):
  - state = CLEAR, sweep counter = 0;
  - out = 0, out_valid = 0, busy = 1.
  - The memory array itself is not reset.
- States: CLEAR and IDLE.
- CLEAR state:
  - Each rising edge writes INIT_VALUE to mem[counter], then increments counter.
  - After the edge that writes address 2^ADDRESS_WIDTH-1: counter wraps to 0, state goes to IDLE, busy goes 0.
  - A sweep therefore occupies exactly 2^ADDRESS_WIDTH edges after rst_n deasserts.
- IDLE with clear = 1 at an edge:
  - state goes to CLEAR at that edge, counter = 0, busy = 1.
  - A load presented in that same cycle is still performed first; the sweep later overwrites it.
  - A rd_en presented in that same cycle is still performed; out and out_valid update normally.
- During CLEAR, the following have no effect:
  - load (memory is not written with in);
  - rd_en (out holds, out_valid = 0);
  - clear (no restart).
- IDLE write: load = 1 writes mem[address] <= in at the edge.
- IDLE read:
  - rd_en = 1 updates out <= mem[address] at the edge, and out_valid = 1 during the following cycle.
  - Read latency is 1 clock.
  - rd_en = 0: out holds its last value, out_valid = 0.
- IDLE, load and rd_en both high at the same address:
  - RDW_MODE = 0: out = in.
  - RDW_MODE = 1: out = the previous contents.
  - The write always occurs.
- IDLE, load and rd_en both high at different addresses: both operations occur independently.
- Reset during a sweep: the sweep restarts from address 0 once rst_n deasserts; there is no partial resume.
- Address width: address is exactly ADDRESS_WIDTH bits, so there are no out-of-range addresses.
- Implementation: one array, one write port. The write-port mux is sweep ? (counter, INIT_VALUE) : (address, in).

Test Plan:
- Test 1, reset sweep (ADDRESS_WIDTH = 4, INIT_VALUE = 16'hFFFF):
  - Stimulus: deassert rst_n, then count edges while busy = 1.
  - Required: busy is high for exactly 16 edges.
  - Then rd_en over addresses 0..15 -> every out = 16'hFFFF, each with out_valid high one cycle after the request.
- Test 2, full write/read (default ADDRESS_WIDTH = 14):
  - Stimulus: wait for busy = 0, write in = 16'h5A5A + i to all 16384 addresses, then read all back.
  - Required: out = 16'h5A5A + i, one cycle after each request; address 16383 reads 16'h9A59.
- Test 3, read-during-write:
  - Stimulus: mem[5] = 16'h1234, then load = 1 and rd_en = 1 at address 5 with in = 16'hABCD.
  - Required with RDW_MODE = 0: out = 16'hABCD.
  - Required with RDW_MODE = 1: out = 16'h1234.
  - In both modes, a subsequent read of address 5 -> 16'hABCD.
- Test 4, accesses ignored while busy:
  - Stimulus: pulse clear in IDLE, then during busy drive load = 1 to address 3 with in = 16'h7777, and rd_en = 1.
  - Required: out_valid stays 0 throughout the sweep.
  - After busy falls, a read of address 3 returns INIT_VALUE.
- Test 5, reset mid-sweep:
  - Stimulus: assert rst_n low asynchronously, between clock edges, while busy = 1 and the counter is at 9.
  - Required: out = 0 and out_valid = 0 immediately, while busy stays 1.
  - After release, busy is high for a full 2^ADDRESS_WIDTH edges.
- Test 6, clear coincident with load and rd_en in IDLE:
  - Stimulus: clear = 1, load = 1 and rd_en = 1 in one cycle at address 2, with in = 16'h0F0F (address 2 held a known value before).
  - Required: out = the previous contents of address 2 with out_valid = 1 in RDW_MODE 1, or out = 16'h0F0F with out_valid = 1 in RDW_MODE 0.
  - busy = 1 from the next cycle.
  - After the sweep, a read of address 2 returns INIT_VALUE.

Source files
------------

// File: rtl/ram_param_clr.sv
// Parametrised single-port RAM with a registered read, a selectable read-during-write mode,
// and a clear sweep that writes INIT_VALUE to every word after reset or on request.
module ram_param_clr #(
  parameter int                    ADDRESS_WIDTH = 14,
  parameter int                    DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter int                    RDW_MODE      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    in,
  input  logic                     load,
  input  logic                     rd_en,
  input  logic                     clear,
  output logic [DATA_WIDTH-1:0]    out,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]               state;
  logic [ADDRESS_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     sweep;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [DATA_WIDTH-1:0]    rd_data_p0;

  assign sweep = (state == CLEAR);
  assign busy  = sweep;

  // Single write port shared by the sweep and the bus.
  assign wr_en   = sweep | load;
  assign wr_addr = sweep ? counter : address;
  assign wr_data = sweep ? INIT_VALUE : in;

  // Bus read and write share one address, so a load in the same cycle is always a collision.
  assign rd_data_p0 = (RDW_MODE == 0 && load) ? in : mem[address];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // p0 -> p1: control state and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      counter   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (sweep) begin
      counter   <= counter + 1'b1;
      out_valid <= 1'b0;
      if (counter == {ADDRESS_WIDTH{1'b1}}) state <= IDLE;
    end else begin
      out_valid <= rd_en;
      if (rd_en) out <= rd_data_p0;
      if (clear) begin
        state   <= CLEAR;
        counter <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_param_clr.sv
// Bench for ram_param_clr: a full-size write-first instance and a 16-word read-first instance
// with INIT_VALUE 16'hFFFF, checked against a reference model and a read scoreboard.
module tb_ram_param_clr;

  logic clk;
  logic rst_n;

  logic [13:0] address0;
  logic [15:0] in0, out0;
  logic        load0, rd0, clear0, vld0, busy0;

  logic [3:0]  address1;
  logic [15:0] in1, out1;
  logic        load1, rd1, clear1, vld1, busy1;

  ram_param_clr #(.ADDRESS_WIDTH(14), .DATA_WIDTH(16), .INIT_VALUE(16'h0000), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .address(address0), .in(in0), .load(load0), .rd_en(rd0),
    .clear(clear0), .out(out0), .out_valid(vld0), .busy(busy0));

  ram_param_clr #(.ADDRESS_WIDTH(4), .DATA_WIDTH(16), .INIT_VALUE(16'hFFFF), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .address(address1), .in(in1), .load(load1), .rd_en(rd1),
    .clear(clear1), .out(out1), .out_valid(vld1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mdl0 [16384];
  logic [15:0] mdl1 [16];
  int          sweep_left [2];
  bit          pushed [2];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int depth(input int k);
    return (k == 0) ? 16384 : 16;
  endfunction

  function automatic logic [15:0] initv(input int k);
    return (k == 0) ? 16'h0000 : 16'hFFFF;
  endfunction

  function automatic logic [15:0] mget(input int k, input logic [13:0] a);
    return (k == 0) ? mdl0[a] : mdl1[a[3:0]];
  endfunction

  task automatic mset(input int k, input logic [13:0] a, input logic [15:0] v);
    if (k == 0) mdl0[a] = v;
    else mdl1[a[3:0]] = v;
  endtask

  task automatic mfill(input int k);
    for (int i = 0; i < depth(k); i++) mset(k, i[13:0], initv(k));
  endtask

  task automatic idle_inputs();
    address0 = '0; in0 = '0; load0 = 0; rd0 = 0; clear0 = 0;
    address1 = '0; in1 = '0; load1 = 0; rd1 = 0; clear1 = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sweep_left[k] = depth(k);
      pushed[k] = 0;
      mfill(k);
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock: drive instance s, advance both models, then check both instances after the edge.
  task automatic cycle(input int s, input logic [13:0] a, input logic [15:0] d,
                       input bit l, input bit r, input bit c);
    logic [15:0] exp, o;
    logic        b, v;
    idle_inputs();
    if (s == 0) begin
      address0 = a; in0 = d; load0 = l; rd0 = r; clear0 = c;
    end else begin
      address1 = a[3:0]; in1 = d; load1 = l; rd1 = r; clear1 = c;
    end
    for (int k = 0; k < 2; k++) begin
      pushed[k] = 0;
      if (sweep_left[k] > 0) sweep_left[k]--;
      else if (k == s) begin
        if (r) begin
          exp = (l && k == 0) ? d : mget(k, a);
          if (k == 0) q0.push_back(exp); else q1.push_back(exp);
          pushed[k] = 1;
        end
        if (l) mset(k, a, d);
        if (c) begin
          sweep_left[k] = depth(k);
          mfill(k);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? busy0 : busy1;
      v = (k == 0) ? vld0 : vld1;
      o = (k == 0) ? out0 : out1;
      chk($sformatf("busy%0d", k), {15'b0, b}, {15'b0, sweep_left[k] > 0});
      chk($sformatf("out_valid%0d", k), {15'b0, v}, {15'b0, pushed[k]});
      if (pushed[k]) begin
        exp = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("out%0d@%0h", k, a), o, exp);
      end
    end
    idle_inputs();
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("rst_out0", out0, 16'h0);
    chk("rst_vld0", {15'b0, vld0}, 16'h0);
    chk("rst_busy0", {15'b0, busy0}, 16'h1);
    chk("rst_busy1", {15'b0, busy1}, 16'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Reset sweep on the 16-word instance lasts exactly 16 edges, then every word reads INIT.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1) break;
      cnt++;
      cycle(1, '0, '0, 0, 0, 0);
    end
    chk("t1_sweep_len", cnt[15:0], 16'd16);
    for (int i = 0; i < 16; i++) cycle(1, i[13:0], '0, 0, 1, 0);

    while (sweep_left[0] > 0) cycle(0, '0, '0, 0, 0, 0);

    // Full-depth write then read-back.
    for (int i = 0; i < 16384; i++) cycle(0, i[13:0], 16'h5A5A + i[15:0], 1, 0, 0);
    for (int i = 0; i < 16384; i++) cycle(0, i[13:0], '0, 0, 1, 0);
    chk("t2_last_word", out0, 16'h9A59);

    // Read-during-write on both modes.
    cycle(0, 14'd5, 16'h1234, 1, 0, 0);
    cycle(0, 14'd5, 16'hABCD, 1, 1, 0);
    chk("t3_wf_out", out0, 16'hABCD);
    cycle(0, 14'd5, '0, 0, 1, 0);
    cycle(1, 14'd5, 16'h1234, 1, 0, 0);
    cycle(1, 14'd5, 16'hABCD, 1, 1, 0);
    chk("t3_rf_out", out1, 16'h1234);
    cycle(1, 14'd5, '0, 0, 1, 0);
    chk("t3_rf_after", out1, 16'hABCD);
    cycle(1, 14'd7, 16'h4321, 1, 1, 0);

    // Accesses during a requested sweep are ignored.
    cycle(1, '0, '0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(1, 14'd3, 16'h7777, 1, 1, (i == 4));
    cycle(1, 14'd3, '0, 0, 1, 0);
    chk("t4_addr3", out1, 16'hFFFF);

    // Clear coincident with load and read.
    cycle(1, 14'd2, 16'h2222, 1, 0, 0);
    cycle(1, 14'd2, 16'h0F0F, 1, 1, 1);
    chk("t6_rf_out", out1, 16'h2222);
    for (int i = 0; i < 16; i++) cycle(1, '0, '0, 0, 0, 0);
    cycle(1, 14'd2, '0, 0, 1, 0);
    chk("t6_rf_after", out1, 16'hFFFF);
    cycle(0, 14'd2, 16'h1111, 1, 0, 0);
    cycle(0, 14'd2, 16'h0F0F, 1, 1, 1);
    chk("t6_wf_out", out0, 16'h0F0F);

    // Reset between edges with the 16-word sweep counter at 9.
    cycle(1, '0, '0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(1, '0, '0, 0, 0, 0);
    chk("t5_pre_out1", out1, 16'hFFFF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_out1", out1, 16'h0);
    chk("t5_vld1", {15'b0, vld1}, 16'h0);
    chk("t5_busy1", {15'b0, busy1}, 16'h1);
    chk("t5_out0", out0, 16'h0);
    #1;
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1) break;
      cnt++;
      cycle(1, '0, '0, 0, 0, 0);
    end
    chk("t5_sweep_len", cnt[15:0], 16'd16);
    cycle(1, 14'd9, '0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
